rf_display_scanner: RTL



---
 rtl/rf_display_pkg.sv | 27 ++
 rtl/rf_display_scanner_btn_debounce.sv | 55 +++++
 rtl/rf_display_scanner.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/rf_display_pkg.sv
// Shared types and defaults for the register-file display scanner.
// Latency: none (types, constants and pure functions only).
// Backpressure: not applicable.
package rf_display_pkg;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, LATCH} state_t;
    typedef enum logic [1:0] {NONE, INC, DEC} step_t;

    localparam int DEF_DEBOUNCE_CYCLES = 1000000;
    localparam int DEF_AUTO_CYCLES     = 50000000;
    localparam int DEF_REFRESH_CYCLES  = 500000;

    // Counter width able to hold n-1, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // One-entry step store: same direction overwrites, opposite directions cancel.
    function automatic step_t merge_step(input step_t cur, input step_t nw);
        if (nw == NONE)
            return cur;
        if (cur == NONE || cur == nw)
            return nw;
        return NONE;
    endfunction

endpackage

// File: rtl/rf_display_scanner_btn_debounce.sv
// Push-button synchronizer + debouncer producing a one-cycle press pulse.
// Latency: 2 sync cycles + DEBOUNCE_CYCLES stable samples, pulse registered.
// Backpressure: none; a held button yields exactly one pulse.
module btn_debounce
    import rf_display_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic press
);

    localparam int            CW      = cnt_w(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync_a;
    logic          sync_b;
    logic          level;
    logic [CW-1:0] cnt;

    // Two-flop synchronizer for the asynchronous button input.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_a <= 1'b0;
            sync_b <= 1'b0;
        end else begin
            sync_a <= btn;
            sync_b <= sync_a;
        end
    end

    // Count consecutive samples that differ from the accepted level; any return
    // to the accepted level restarts the count. Rising acceptance emits a pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt   <= '0;
            level <= 1'b0;
            press <= 1'b0;
        end else begin
            press <= 1'b0;
            if (sync_b == level) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                cnt   <= '0;
                level <= sync_b;
                press <= sync_b;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/rf_display_scanner.sv
// Register-file display scanner: button/auto stepping, read issue, stable display value.
// Latency: step accepted in IDLE at t -> rf_rd_en at t+1 -> disp_upd/disp_val at t+2+RD_LAT.
// Backpressure: none; one pending step is kept, newer steps overwrite, opposite steps cancel.
// Build option RF_DISPLAY_SHOW_ADDR_EN: top byte of disp_val shows the latched address.
module rf_display_scanner
    import rf_display_pkg::*;
#(
    parameter int ADDR_W          = 5,
    parameter int DATA_W          = 32,
    parameter int RD_LAT          = 1,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int AUTO_CYCLES     = DEF_AUTO_CYCLES,
    parameter int REFRESH_CYCLES  = DEF_REFRESH_CYCLES
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              btn_next,
    input  logic              btn_prev,
    input  logic              auto_en,
    output logic [ADDR_W-1:0] rf_addr,
    output logic              rf_rd_en,
    input  logic [DATA_W-1:0] rf_rd_data,
    output logic [DATA_W-1:0] disp_val,
    output logic [ADDR_W-1:0] disp_addr,
    output logic              disp_upd
);

    localparam int             AW       = cnt_w(AUTO_CYCLES);
    localparam int             RW       = cnt_w(REFRESH_CYCLES);
    localparam logic [AW-1:0]  AUTO_MAX = AW'(AUTO_CYCLES - 1);
    localparam logic [RW-1:0]  REF_MAX  = RW'(REFRESH_CYCLES - 1);

    logic          next_pulse;
    logic          prev_pulse;
    logic          any_pulse;
    logic          auto_tick;
    logic          consume;
    logic [AW-1:0] auto_cnt;
    logic [RW-1:0] ref_cnt;
    logic [1:0]    lat_cnt;
    step_t         step;
    step_t         pending;
    step_t         pending_base;
    state_t        state;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_next (
        .clk   (clk),
        .reset (reset),
        .btn   (btn_next),
        .press (next_pulse)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_prev (
        .clk   (clk),
        .reset (reset),
        .btn   (btn_prev),
        .press (prev_pulse)
    );

    assign any_pulse = next_pulse | prev_pulse;
    assign auto_tick = auto_en && !any_pulse && (auto_cnt == AUTO_MAX);
    assign consume   = (state == IDLE) && (pending != NONE);

    // Per-cycle step arbitration: simultaneous buttons cancel, buttons beat the auto tick.
    always_comb begin
        step = NONE;
        if (next_pulse && prev_pulse)
            step = NONE;
        else if (next_pulse)
            step = INC;
        else if (prev_pulse)
            step = DEC;
        else if (auto_tick)
            step = INC;
        pending_base = consume ? NONE : pending;
    end

    // Auto-step timer: runs only with auto_en, restarted by any button pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            auto_cnt <= '0;
        else if (!auto_en || any_pulse || auto_cnt == AUTO_MAX)
            auto_cnt <= '0;
        else
            auto_cnt <= auto_cnt + AW'(1);
    end

    // Pending step register; a step arriving while IDLE consumes the old one is kept.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            pending <= NONE;
        else
            pending <= merge_step(pending_base, step);
    end

    // Read sequencer. rf_rd_en is registered so it is high exactly in the REQ cycle;
    // the display registers load on the last WAIT edge so they are valid during LATCH.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= REQ;
            rf_addr   <= '0;
            rf_rd_en  <= 1'b0;
            disp_val  <= '0;
            disp_addr <= '0;
            disp_upd  <= 1'b0;
            ref_cnt   <= '0;
            lat_cnt   <= '0;
        end else begin
            rf_rd_en <= 1'b0;
            disp_upd <= 1'b0;
            case (state)
                IDLE: begin
                    if (pending != NONE) begin
                        rf_addr  <= (pending == INC) ? rf_addr + ADDR_W'(1) : rf_addr - ADDR_W'(1);
                        rf_rd_en <= 1'b1;
                        ref_cnt  <= '0;
                        state    <= REQ;
                    end else if (ref_cnt == REF_MAX) begin
                        rf_rd_en <= 1'b1;
                        ref_cnt  <= '0;
                        state    <= REQ;
                    end else begin
                        ref_cnt <= ref_cnt + RW'(1);
                    end
                end
                REQ: begin
                    // Coming out of reset the strobe is still low: raise it first.
                    if (!rf_rd_en) begin
                        rf_rd_en <= 1'b1;
                    end else begin
                        lat_cnt <= 2'(RD_LAT - 1);
                        state   <= WAIT;
                    end
                end
                WAIT: begin
                    if (lat_cnt == 2'd0) begin
`ifdef RF_DISPLAY_SHOW_ADDR_EN
                        disp_val <= {{(DATA_W-24-ADDR_W){1'b0}}, rf_addr, rf_rd_data[23:0]};
`else
                        disp_val <= rf_rd_data;
`endif
                        disp_addr <= rf_addr;
                        disp_upd  <= 1'b1;
                        state     <= LATCH;
                    end else begin
                        lat_cnt <= lat_cnt - 2'd1;
                    end
                end
                LATCH: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
